stopwatch_ctrl: RTL and testbench

Control sequencer for the 00–59 seconds counter datapath. Converts three raw pushbuttons (start/stop, clear, lap) into debounced single-cycle events. Runs a four-state stopwatch FSM. Drives the counter's count enable, a synchronous clear pulse, a display-freeze flag and a gated 1 Hz tick. Sits between the board buttons and the counter/seven-segment datapath, on the same 1 MHz clock.

---
 rtl/stopwatch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced start/clear/lap events, 4-state FSM, counter enable/clear,
// display freeze and gated tick. Optional lap feature compiled in with LAP_EN.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TICK_DIV        = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_CLEAR,
    input  logic       BTN_LAP,
    output logic       run_en,
    output logic       tick,
    output logic       cnt_clr,
    output logic       lap_hold,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

`ifdef LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [NB-1:0] btn_raw_s;
    logic [NB-1:0] sync1_q, sync2_q, lvl_q, lvl_prev_q, press_q;
    logic [CW-1:0] db_cnt_q [NB];
    logic [PW-1:0] pre_q;
    state_t        state_q, state_d;
    logic          clr_d, start_ev_s, clear_ev_s, lap_ev_s, running_s, lap_d;

`ifdef LAP_EN
    assign btn_raw_s = {BTN_LAP, BTN_CLEAR, BTN_START};
    assign lap_ev_s  = press_q[2];
`else
    logic unused_lap_s;
    assign unused_lap_s = BTN_LAP;
    assign btn_raw_s    = {BTN_CLEAR, BTN_START};
    assign lap_ev_s     = 1'b0;
`endif
    assign start_ev_s = press_q[0];
    assign clear_ev_s = press_q[1];
    assign running_s  = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign state      = state_q;

    // Button front end: synchronizer, stability counter, accepted level and rising-edge event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= {NB{1'b0}};
            sync2_q    <= {NB{1'b0}};
            lvl_q      <= {NB{1'b0}};
            lvl_prev_q <= {NB{1'b0}};
            press_q    <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_q    <= btn_raw_s;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
            press_q    <= lvl_q & ~lvl_prev_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    db_cnt_q[i] <= {CW{1'b0}};
                end else if (db_cnt_q[i] == DB_LAST) begin
                    lvl_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= {CW{1'b0}};
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Next-state decode; each event is honoured only where it is legal, clear > start > lap.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_ev_s) begin
                    clr_d = 1'b1;
                end else if (start_ev_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_ev_s) begin
                    state_d = ST_PAUSE;
                end else if (lap_ev_s) begin
                    state_d = ST_LAP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LAP: begin
                if (start_ev_s) begin
                    state_d = ST_PAUSE;
                end else if (lap_ev_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (clear_ev_s) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_ev_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef LAP_EN
    assign lap_d = (state_d == ST_LAP);
`else
    assign lap_d = 1'b0;
`endif

    // State, outputs decoded from the next state, and the phase-preserving tick prescaler.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            run_en   <= 1'b0;
            lap_hold <= 1'b0;
            cnt_clr  <= 1'b0;
            tick     <= 1'b0;
            pre_q    <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            run_en   <= (state_d == ST_RUN) || (state_d == ST_LAP);
            lap_hold <= lap_d;
            cnt_clr  <= clr_d;
            tick     <= running_s && (pre_q == PRE_LAST);
            if ((state_d == ST_IDLE) || clr_d) begin
                pre_q <= {PW{1'b0}};
            end else if (running_s) begin
                pre_q <= (pre_q == PRE_LAST) ? {PW{1'b0}} : pre_q + PW'(1);
            end else begin
                pre_q <= pre_q;
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized button activity, checked every cycle
// against a window/event-count model of the stopwatch.
module tb_stopwatch_ctrl;
    localparam int DB = 4;
    localparam int TD = 10;
`ifdef LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, b_start = 1'b0, b_clear = 1'b0, b_lap = 1'b0;
    logic run_en, tick, cnt_clr, lap_hold;
    logic [1:0] state;

    int n_chk = 0, n_pass = 0;
    bit chk_on = 1'b0;

    // model state
    bit m_raw1[3], m_raw2[3];
    bit m_win[3][DB];
    bit m_lvl[3], m_lvlp[3], m_press[3];
    int m_state = 0, m_runs = 0;
    bit m_run = 1'b0, m_lap = 1'b0, m_clr = 1'b0, m_tick = 1'b0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .CLK(clk), .RST(rst), .BTN_START(b_start), .BTN_CLEAR(b_clear), .BTN_LAP(b_lap),
        .run_en(run_en), .tick(tick), .cnt_clr(cnt_clr), .lap_hold(lap_hold), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(bit r, bit [2:0] raw);
        bit ev[3];
        bit all_diff, running_old, clr;
        int nxt;
        if (r) begin
            for (int b = 0; b < 3; b++) begin
                m_raw1[b] = 0; m_raw2[b] = 0; m_lvl[b] = 0; m_lvlp[b] = 0; m_press[b] = 0;
                for (int k = 0; k < DB; k++) m_win[b][k] = 0;
            end
            m_state = 0; m_runs = 0; m_run = 0; m_lap = 0; m_clr = 0; m_tick = 0;
            return;
        end
        for (int b = 0; b < 3; b++) begin
            bit seen;
            ev[b] = m_press[b];
            seen = m_raw2[b];
            m_raw2[b] = m_raw1[b];
            m_raw1[b] = raw[b];
            m_press[b] = m_lvl[b] & !m_lvlp[b];
            m_lvlp[b] = m_lvl[b];
            for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
            m_win[b][0] = seen;
            all_diff = 1;
            for (int k = 0; k < DB; k++) if (m_win[b][k] == m_lvl[b]) all_diff = 0;
            if (all_diff) m_lvl[b] = !m_lvl[b];
        end
        if (!LAP_ON) ev[2] = 0;
        running_old = (m_state == 1) || (m_state == 3);
        nxt = m_state;
        clr = 0;
        case (m_state)
            0: if (ev[1]) clr = 1; else if (ev[0]) nxt = 1;
            1: if (ev[0]) nxt = 2; else if (ev[2]) nxt = 3;
            3: if (ev[0]) nxt = 2; else if (ev[2]) nxt = 1;
            default: if (ev[1]) begin nxt = 0; clr = 1; end else if (ev[0]) nxt = 1;
        endcase
        if (running_old) begin
            m_runs++;
            m_tick = (m_runs % TD == 0);
        end else begin
            m_tick = 0;
        end
        if (nxt == 0 || clr) m_runs = 0;
        m_state = nxt;
        m_run = (nxt == 1) || (nxt == 3);
        m_lap = (nxt == 3);
        m_clr = clr;
    endtask

    task automatic cycle(bit r, bit s, bit c, bit l);
        rst = r; b_start = s; b_clear = c; b_lap = l;
        @(posedge clk);
        model_step(r, {l, c, s});
        @(negedge clk);
    endtask

    task automatic run_n(int n, bit s, bit c, bit l);
        for (int i = 0; i < n; i++) cycle(1'b0, s, c, l);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("state", state, m_state);
            check("run_en", run_en, m_run);
            check("tick", tick, m_tick);
            check("cnt_clr", cnt_clr, m_clr);
            check("lap_hold", lap_hold, m_lap);
        end
    end

    initial begin
        bit [2:0] raw;
        cycle(1'b1, 0, 0, 0);
        chk_on = 1'b1;
        cycle(1'b1, 0, 0, 0);
        check("rst_state", state, 0);
        check("rst_run_en", run_en, 0);

        // short glitch: no event
        run_n(3, 0, 0, 0);
        run_n(3, 1, 0, 0);
        run_n(15, 0, 0, 0);
        check("glitch_state", state, 0);

        // press latency and tick spacing
        run_n(7, 1, 0, 0);
        check("press_early_state", state, 0);
        run_n(1, 1, 0, 0);
        check("press_state", state, 1);
        check("press_run_en", run_en, 1);
        run_n(9, 1, 0, 0);
        check("tick1_early", tick, 0);
        run_n(1, 1, 0, 0);
        check("tick1", tick, 1);
        run_n(9, 1, 0, 0);
        check("tick2_early", tick, 0);
        run_n(1, 1, 0, 0);
        check("tick2", tick, 1);

        // pause at prescaler 6, resume preserves phase
        run_n(8, 0, 0, 0);
        run_n(7, 1, 0, 0);
        run_n(1, 1, 0, 0);
        check("pause_state", state, 2);
        check("pause_run_en", run_en, 0);
        run_n(28, 0, 0, 0);
        check("pause_no_tick", tick, 0);
        run_n(8, 1, 0, 0);
        check("resume_state", state, 1);
        run_n(3, 1, 0, 0);
        check("resume_tick_early", tick, 0);
        run_n(1, 1, 0, 0);
        check("resume_tick", tick, 1);

        // clear and start together in PAUSE
        run_n(8, 0, 0, 0);
        run_n(8, 1, 0, 0);
        check("pause2_state", state, 2);
        run_n(8, 0, 0, 0);
        run_n(7, 1, 1, 0);
        check("clr_early", cnt_clr, 0);
        run_n(1, 1, 1, 0);
        check("clr_pulse", cnt_clr, 1);
        check("clr_state", state, 0);
        check("clr_run_en", run_en, 0);
        run_n(1, 1, 1, 0);
        check("clr_width", cnt_clr, 0);

        // lap
        run_n(8, 0, 0, 0);
        run_n(8, 1, 0, 0);
        run_n(8, 0, 0, 0);
        run_n(8, 0, 0, 1);
        check("lap_state", state, LAP_ON ? 3 : 1);
        check("lap_hold_on", lap_hold, LAP_ON ? 1 : 0);
        run_n(8, 0, 0, 0);
        run_n(8, 0, 0, 1);
        check("unlap_state", state, 1);
        check("unlap_hold", lap_hold, 0);

        // reset while running
        run_n(5, 0, 0, 0);
        cycle(1'b1, 0, 0, 0);
        check("rr_state", state, 0);
        check("rr_outs", {run_en, tick, cnt_clr, lap_hold}, 0);
        run_n(8, 1, 0, 0);
        check("rr_start", state, 1);
        run_n(9, 1, 0, 0);
        check("rr_tick_early", tick, 0);
        run_n(1, 1, 0, 0);
        check("rr_tick", tick, 1);
        run_n(8, 0, 0, 0);

        // randomized button activity
        raw = 3'b000;
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            raw[$urandom_range(0, 2)] ^= 1'b1;
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                cycle(($urandom_range(0, 199) == 0), raw[0], raw[1], raw[2]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
